// File: rtl/sdram_frame_reader.sv
// sdram_frame_reader: fetches a linear frame buffer from SDRAM in fixed bursts into a FIFO for scan-out.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   frame_start           vsync pulse; restarts the frame at address 0
//   rd_burst_req/len/addr burst read request to the SDRAM controller
//   rd_burst_data_valid/rd_burst_data/rd_burst_finish  burst read return path
//   pix_rd_en, pix_data   FIFO pop and registered popped word
//   fifo_level, underflow FIFO occupancy and sticky empty-pop flag
module sdram_frame_reader #(
  parameter int BURST_LEN   = 128,
  parameter int FRAME_WORDS = 786432,
  parameter int FIFO_DEPTH  = 512
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  output logic                          rd_burst_req,
  output logic [9:0]                    rd_burst_len,
  output logic [23:0]                   rd_burst_addr,
  input  logic                          rd_burst_data_valid,
  input  logic [15:0]                   rd_burst_data,
  input  logic                          rd_burst_finish,
  input  logic                          pix_rd_en,
  output logic [15:0]                   pix_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, READ = 3'd2, NEXT = 3'd3, WAIT_FRAME = 3'd4;
  logic [2:0] state_q, state_d;
  logic req_q, req_d, pend_q, pend_d, unf_q, unf_d;
  logic [23:0] addr_q, addr_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [15:0] pix_q, pix_d;
  logic [15:0] mem [FIFO_DEPTH];
  logic flush, push, pop, space, last;
  always_comb begin
    // A pending frame restart is serviced only from IDLE so an in-flight burst always drains first.
    flush = state_q == IDLE && pend_q;
    push = rd_burst_data_valid && (state_q == REQ || state_q == READ);
    pop = pix_rd_en && lvl_q != '0 && !flush;
    space = lvl_q <= LW'(FIFO_DEPTH - BURST_LEN);
    last = addr_q == 24'(FRAME_WORDS - BURST_LEN);
    state_d = state_q;
    addr_d = flush ? '0 : addr_q;
    case (state_q)
      IDLE: state_d = !pend_q && space ? REQ : IDLE;
      REQ: state_d = !rd_burst_data_valid ? REQ : rd_burst_finish ? NEXT : READ;
      READ: state_d = rd_burst_finish ? NEXT : READ;
      NEXT: begin
        state_d = !pend_q && last ? WAIT_FRAME : IDLE;
        addr_d = pend_q ? addr_q : last ? '0 : addr_q + 24'(BURST_LEN);
      end
      WAIT_FRAME: state_d = pend_q ? IDLE : WAIT_FRAME;
      default: state_d = IDLE;
    endcase
    req_d = state_d == REQ;
    pend_d = frame_start || (pend_q && !flush);
    unf_d = flush ? 1'b0 : unf_q || (pix_rd_en && lvl_q == '0);
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(pop);
    lvl_d = flush ? '0 : lvl_q + LW'(push) - LW'(pop);
    pix_d = pop ? mem[rd_q] : pix_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      req_q <= 1'b0;
      pend_q <= 1'b0;
      unf_q <= 1'b0;
      addr_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      pix_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      pend_q <= pend_d;
      unf_q <= unf_d;
      addr_q <= addr_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      pix_q <= pix_d;
    end
  // Storage carries no reset; occupancy is tracked by the pointers and level alone.
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= rd_burst_data;
  assign rd_burst_req = req_q;
  assign rd_burst_len = 10'(BURST_LEN);
  assign rd_burst_addr = addr_q;
  assign pix_data = pix_q;
  assign fifo_level = lvl_q;
  assign underflow = unf_q;
endmodule
